redas_pe_mc: RTL and testbench

- Multi-context, parametrised REDAS processing element for the systolic array fabric.
- Each PE holds a bank of NUM_CTX signed stationary weights and computes operand × stationary with a signed 2-stage pipeline.
- Two calculation patterns:
  - Pass-through MAC: adds the neighbour's partial sum.
  - Local accumulation: sums ACC_LEN products internally before emitting one result.
- Array orientation is selectable per PE (vertical or horizontal flow). Array-level glue instantiates an R×C grid of these blocks.

---
 rtl/redas_pkg.sv | 49 ++++
 rtl/redas_stationary_bank.sv | 48 ++++
 rtl/redas_pe_mc.sv | 223 ++++++++++++++++++++++
 tb/tb_redas_pe_mc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/redas_pkg.sv
// -----------------------------------------------------------------------------
// redas_pkg
// Shared types and helpers for the REDAS multi-context processing element.
//   calc_mode_e  : pass-through MAC or local accumulation
//   flow_dir_e   : vertical or horizontal data flow through the PE
//   acc_state_e  : local-accumulation controller states
//   sat_narrow() : clamp (or pass through for later truncation) a wide signed
//                  value to a signed out_w-bit range
// -----------------------------------------------------------------------------
package redas_pkg;

  typedef enum logic {
    CALC_MAC = 1'b0,
    CALC_ACC = 1'b1
  } calc_mode_e;

  typedef enum logic {
    FLOW_VERT  = 1'b0,
    FLOW_HORIZ = 1'b1
  } flow_dir_e;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_ACCUM = 2'd1,
    ACC_EMIT  = 2'd2
  } acc_state_e;

  // Width of the common carrier used by sat_narrow; every internal value
  // (products, sums, accumulator) is sign-extended into it before narrowing.
  localparam int unsigned SAT_W = 64;

  // Returns val clamped to [-2^(out_w-1), 2^(out_w-1)-1] when saturate is set,
  // otherwise val unchanged so the caller's narrowing cast wraps it.
  function automatic logic signed [SAT_W-1:0] sat_narrow(
    input logic signed [SAT_W-1:0] val,
    input int unsigned             out_w,
    input logic                    saturate
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (!saturate)     return val;
    if (val > max_v)   return max_v;
    if (val < min_v)   return min_v;
    return val;
  endfunction

endpackage

// File: rtl/redas_stationary_bank.sv
// -----------------------------------------------------------------------------
// redas_stationary_bank
// NUM_CTX x DATA_WIDTH signed register file holding the stationary weights.
//   clk, rst_n  : clock, synchronous active-low reset (clears every entry)
//   i_wr_en     : write strobe
//   i_wr_idx    : entry written on the next rising edge
//   i_wr_data   : value written
//   i_rd_idx    : entry read
//   o_rd_data   : combinational read of the current register contents, so a
//                 same-cycle write to the read entry still returns the old value
// -----------------------------------------------------------------------------
module redas_stationary_bank
  import redas_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CTX    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_wr_en,
  input  logic [$clog2(NUM_CTX)-1:0]    i_wr_idx,
  input  logic signed [DATA_WIDTH-1:0]  i_wr_data,
  input  logic [$clog2(NUM_CTX)-1:0]    i_rd_idx,
  output logic signed [DATA_WIDTH-1:0]  o_rd_data
);

  localparam int IDX_W = $clog2(NUM_CTX);

  logic signed [DATA_WIDTH-1:0] r_stat [NUM_CTX];
  logic [NUM_CTX-1:0]           w_we;

  for (genvar gi = 0; gi < NUM_CTX; gi++) begin : g_we
    assign w_we[gi] = i_wr_en && (i_wr_idx == IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (w_we[i]) r_stat[i] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_stat[i_rd_idx];

endmodule

// File: rtl/redas_pe_mc.sv
// -----------------------------------------------------------------------------
// redas_pe_mc
// Multi-context REDAS processing element: operand x stationary with a 2-stage
// signed pipeline, either added to a neighbour's partial sum (MAC) or summed
// locally over acc_len products (accumulation).
//   clk, rst_n              : clock, synchronous active-low reset
//   in_top/bottom/left/right: neighbour inputs (operand or psum by flow_dir)
//   in_valid, stall         : input qualifier, global pipeline freeze
//   flow_dir, calc_mode     : orientation and calculation pattern
//   acc_len, flush          : accumulation length (0 acts as 1), early emit
//   store_stationary,
//   stat_wr_idx, stat_rd_idx: stationary bank write / compute context select
//   out_top/bottom/left/right: result and forwarded operand, unused ones 0
//   out_valid               : result valid
// -----------------------------------------------------------------------------
module redas_pe_mc
  import redas_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int NUM_CTX     = 4,
  parameter int MAX_ACC_LEN = 256,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic signed [DATA_WIDTH-1:0]         in_top,
  input  logic signed [DATA_WIDTH-1:0]         in_bottom,
  input  logic signed [DATA_WIDTH-1:0]         in_left,
  input  logic signed [DATA_WIDTH-1:0]         in_right,
  input  logic                                 in_valid,
  input  logic                                 stall,
  input  logic                                 flow_dir,
  input  logic                                 calc_mode,
  input  logic [$clog2(MAX_ACC_LEN+1)-1:0]     acc_len,
  input  logic                                 flush,
  input  logic                                 store_stationary,
  input  logic [$clog2(NUM_CTX)-1:0]           stat_wr_idx,
  input  logic [$clog2(NUM_CTX)-1:0]           stat_rd_idx,
  output logic signed [DATA_WIDTH-1:0]         out_top,
  output logic signed [DATA_WIDTH-1:0]         out_bottom,
  output logic signed [DATA_WIDTH-1:0]         out_left,
  output logic signed [DATA_WIDTH-1:0]         out_right,
  output logic                                 out_valid
);

  localparam int LEN_W  = $clog2(MAX_ACC_LEN + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;

  // ---------------- orientation decode and stationary bank ----------------
  flow_dir_e                    w_dir;
  calc_mode_e                   w_mode;
  logic signed [DATA_WIDTH-1:0] w_operand;
  logic signed [DATA_WIDTH-1:0] w_psum_in;
  logic signed [DATA_WIDTH-1:0] w_stat_rd;

  assign w_dir     = flow_dir_e'(flow_dir);
  assign w_mode    = calc_mode_e'(calc_mode);
  assign w_operand = (w_dir == FLOW_HORIZ) ? in_left   : in_top;
  assign w_psum_in = (w_dir == FLOW_HORIZ) ? in_bottom : in_right;

  // The psum-side input doubles as the stationary write data.
  redas_stationary_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CTX    (NUM_CTX)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (store_stationary),
    .i_wr_idx  (stat_wr_idx),
    .i_wr_data (w_psum_in),
    .i_rd_idx  (stat_rd_idx),
    .o_rd_data (w_stat_rd)
  );

  // ---------------- stage 1: multiply, capture psum, forward ----------------
  logic                         r_s1_valid;
  logic                         r_s1_flush;
  flow_dir_e                    r_s1_dir;
  logic signed [PROD_W-1:0]     r_prod;
  logic signed [PROD_W-1:0]     r_psum;
  logic signed [DATA_WIDTH-1:0] r_fwd;

  // flush is registered alongside the data so that a flush driven together
  // with an operand lines up with that operand's product in stage 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_flush <= 1'b0;
      r_s1_dir   <= FLOW_VERT;
      r_prod     <= '0;
      r_psum     <= '0;
      r_fwd      <= '0;
    end else if (!stall) begin
      r_s1_valid <= in_valid;
      r_s1_flush <= flush;
      if (in_valid) begin
        r_prod   <= w_operand * w_stat_rd;
        r_psum   <= {{DATA_WIDTH{w_psum_in[DATA_WIDTH-1]}}, w_psum_in};
        r_s1_dir <= w_dir;
        r_fwd    <= w_operand;
      end
    end
  end

  // ---------------- stage 2: MAC sum and accumulation control ----------------
  logic signed [SAT_W-1:0]     w_mac_wide;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic                        w_acc_in;
  logic                        w_first_done;
  logic [LEN_W-1:0]            w_len_eff;
  logic [LEN_W-1:0]            w_cnt_inc;

  acc_state_e                  r_state;
  acc_state_e                  w_state_next;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic [LEN_W-1:0]            r_cnt;
  logic [LEN_W-1:0]            w_cnt_next;
  logic                        w_emit;

  assign w_mac_wide   = SAT_W'(r_prod) + SAT_W'(r_psum);
  assign w_prod_ext   = ACC_WIDTH'(r_prod);
  assign w_acc_in     = r_s1_valid && (w_mode == CALC_ACC);
  assign w_len_eff    = (acc_len == '0) ? LEN_W'(1) : acc_len;
  assign w_cnt_inc    = r_cnt + LEN_W'(1);
  // A product that starts a new accumulation closes it at once when the
  // length is 1 or when a flush travels with it.
  assign w_first_done = (w_len_eff == LEN_W'(1)) || r_s1_flush;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_state <= ACC_IDLE;
    else if (!stall) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACC_IDLE: begin
        if (w_acc_in) w_state_next = w_first_done ? ACC_EMIT : ACC_ACCUM;
      end
      ACC_ACCUM: begin
        if (r_s1_flush || (w_acc_in && (w_cnt_inc >= w_len_eff)))
          w_state_next = ACC_EMIT;
      end
      ACC_EMIT: begin
        if (w_acc_in) w_state_next = w_first_done ? ACC_EMIT : ACC_ACCUM;
        else          w_state_next = ACC_IDLE;
      end
      default: w_state_next = ACC_IDLE;
    endcase
  end

  always_comb begin
    w_acc_next = r_acc;
    w_cnt_next = r_cnt;
    w_emit     = 1'b0;
    case (r_state)
      ACC_IDLE: begin
        if (w_acc_in) begin
          w_acc_next = w_prod_ext;
          w_cnt_next = LEN_W'(1);
        end
      end
      ACC_ACCUM: begin
        if (w_acc_in) begin
          w_acc_next = r_acc + w_prod_ext;
          w_cnt_next = w_cnt_inc;
        end
      end
      ACC_EMIT: begin
        w_emit = 1'b1;
        // A product landing during EMIT seeds the next sum instead of being lost.
        if (w_acc_in) begin
          w_acc_next = w_prod_ext;
          w_cnt_next = LEN_W'(1);
        end else begin
          w_acc_next = '0;
          w_cnt_next = '0;
        end
      end
      default: begin
        w_acc_next = '0;
        w_cnt_next = '0;
      end
    endcase
  end

  // ---------------- result register ----------------
  logic signed [DATA_WIDTH-1:0] r_res;
  flow_dir_e                    r_res_dir;
  logic                         r_out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_res_dir   <= FLOW_VERT;
      r_out_valid <= 1'b0;
    end else if (!stall) begin
      r_acc       <= w_acc_next;
      r_cnt       <= w_cnt_next;
      r_out_valid <= 1'b0;
      if (w_emit) begin
        r_res       <= DATA_WIDTH'(sat_narrow(SAT_W'(r_acc), DATA_WIDTH, SATURATE));
        r_res_dir   <= r_s1_dir;
        r_out_valid <= 1'b1;
      end else if (r_s1_valid && (w_mode == CALC_MAC)) begin
        r_res       <= DATA_WIDTH'(sat_narrow(w_mac_wide, DATA_WIDTH, SATURATE));
        r_res_dir   <= r_s1_dir;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign out_bottom = (r_res_dir == FLOW_VERT)  ? r_res : '0;
  assign out_top    = (r_res_dir == FLOW_HORIZ) ? r_res : '0;
  assign out_left   = (r_s1_dir  == FLOW_VERT)  ? r_fwd : '0;
  assign out_right  = (r_s1_dir  == FLOW_HORIZ) ? r_fwd : '0;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_redas_pe_mc.sv
// -----------------------------------------------------------------------------
// tb_redas_pe_mc
// Directed bench for redas_pe_mc with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_redas_pe_mc;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] in_top, in_bottom, in_left, in_right;
  logic              in_valid, stall, flow_dir, calc_mode, flush, store_stationary;
  logic [8:0]        acc_len;
  logic [1:0]        stat_wr_idx, stat_rd_idx;
  logic signed [7:0] out_top, out_bottom, out_left, out_right;
  logic              out_valid;

  int n_checks = 0;
  int n_errors = 0;

  redas_pe_mc #(
    .DATA_WIDTH  (8),
    .ACC_WIDTH   (24),
    .NUM_CTX     (4),
    .MAX_ACC_LEN (256),
    .SATURATE    (1'b1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_top           (in_top),
    .in_bottom        (in_bottom),
    .in_left          (in_left),
    .in_right         (in_right),
    .in_valid         (in_valid),
    .stall            (stall),
    .flow_dir         (flow_dir),
    .calc_mode        (calc_mode),
    .acc_len          (acc_len),
    .flush            (flush),
    .store_stationary (store_stationary),
    .stat_wr_idx      (stat_wr_idx),
    .stat_rd_idx      (stat_rd_idx),
    .out_top          (out_top),
    .out_bottom       (out_bottom),
    .out_left         (out_left),
    .out_right        (out_right),
    .out_valid        (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_stat(input int idx, input int val, input logic dir);
    flow_dir         = dir;
    store_stationary = 1'b1;
    stat_wr_idx      = 2'(idx);
    if (!dir) in_right  = 8'(val);
    else      in_bottom = 8'(val);
    tick();
    $display("  stat[%0d] <= %0d (flow_dir=%0b)", idx, val, dir);
    store_stationary = 1'b0;
    in_right         = 8'sd0;
    in_bottom        = 8'sd0;
  endtask

  // One vertical-flow cycle in accumulation mode; in_right carries a nonzero
  // value that must be ignored as psum.
  task automatic acc_cycle(input string tag, input logic v, input int op,
                           input logic fl, input logic st,
                           input logic ev, input int eval);
    in_valid = v;
    in_top   = 8'(op);
    in_right = 8'sd7;
    flush    = fl;
    stall    = st;
    tick();
    $display("  [%s] v=%0b op=%0d flush=%0b stall=%0b -> out_valid=%0b out_bottom=%0d",
             tag, v, op, fl, st, out_valid, out_bottom);
    check({tag, "_valid"}, out_valid, ev);
    if (ev) check({tag, "_sum"}, out_bottom, eval);
    in_valid = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    in_right = 8'sd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_top = 0; in_bottom = 0; in_left = 0; in_right = 0;
    in_valid = 0; stall = 0; flow_dir = 0; calc_mode = 0; flush = 0;
    store_stationary = 0; acc_len = 9'd1; stat_wr_idx = 0; stat_rd_idx = 0;

    // ---------------- reset ----------------
    tick(); tick();
    check("rst_valid",  out_valid,  0);
    check("rst_bottom", out_bottom, 0);
    check("rst_top",    out_top,    0);
    check("rst_left",   out_left,   0);
    check("rst_right",  out_right,  0);
    rst_n = 1'b1;

    // ---------------- MAC sweep, stat[0] = 1, pipelined ----------------
    write_stat(0, 1, 1'b0);
    calc_mode = 1'b0; stat_rd_idx = 2'd0;
    for (int c = 0; c <= 400; c++) begin
      if (c < 400) begin
        in_valid = 1'b1;
        in_top   = 8'(-10 + c / 20);
        in_right = 8'(-10 + c % 20);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c < 400) check("mac_fwd", out_left, -10 + c / 20);
      if (c >= 1) begin
        $display("  [mac] n=%0d m=%0d -> out_valid=%0b out_bottom=%0d",
                 -10 + (c - 1) / 20, -10 + (c - 1) % 20, out_valid, out_bottom);
        check("mac_valid", out_valid, 1);
        check("mac_sum", out_bottom, (-10 + (c - 1) / 20) + (-10 + (c - 1) % 20));
      end
    end
    in_valid = 1'b0; in_top = 0; in_right = 0;
    tick();
    check("mac_drain_valid", out_valid, 0);
    check("mac_hold_sum", out_bottom, 18);

    // ---------------- saturation and read-old-on-collision ----------------
    write_stat(1, 127, 1'b0);
    stat_rd_idx = 2'd1;
    in_valid = 1'b1; in_top = 8'sd127; in_right = 8'sd0;
    tick();
    // Same-cycle overwrite of stat[1] with -128 (also the psum): old 127 used.
    in_right = -8'sd128; store_stationary = 1'b1; stat_wr_idx = 2'd1;
    tick();
    check("sat_hi_valid", out_valid, 1);
    check("sat_hi", out_bottom, 127);
    store_stationary = 1'b0; in_right = 8'sd0;
    tick();
    check("sat_collision_old", out_bottom, 127);
    in_valid = 1'b0;
    tick();
    check("sat_lo", out_bottom, -128);
    tick();
    check("sat_idle_valid", out_valid, 0);

    // ---------------- local accumulation, acc_len = 4 ----------------
    write_stat(2, 3, 1'b0);
    calc_mode = 1'b1; acc_len = 9'd4; stat_rd_idx = 2'd2;
    acc_cycle("acc", 1, 1, 0, 0, 0, 0);
    acc_cycle("acc", 1, 2, 0, 0, 0, 0);
    acc_cycle("acc", 1, 3, 0, 0, 0, 0);
    acc_cycle("acc", 1, 4, 0, 0, 0, 0);
    acc_cycle("acc", 0, 0, 0, 0, 0, 0);
    acc_cycle("acc", 0, 0, 0, 0, 1, 30);
    acc_cycle("acc", 0, 0, 0, 0, 0, 0);

    // ---------------- flush and back-to-back, acc_len = 8 ----------------
    write_stat(2, 2, 1'b0);
    acc_len = 9'd8;
    acc_cycle("flush", 1, 5, 0, 0, 0, 0);
    acc_cycle("flush", 1, 5, 0, 0, 0, 0);
    acc_cycle("flush", 1, 5, 1, 0, 0, 0);
    acc_cycle("flush", 1, 1, 0, 0, 0, 0);
    acc_cycle("flush", 1, 4, 0, 0, 1, 30);
    acc_cycle("flush", 0, 0, 0, 0, 0, 0);
    acc_cycle("flush", 0, 0, 1, 0, 0, 0);
    acc_cycle("flush", 0, 0, 0, 0, 0, 0);
    acc_cycle("flush", 0, 0, 0, 0, 1, 10);
    acc_cycle("flush", 0, 0, 0, 0, 0, 0);

    // ---------------- acc_len = 1 and acc_len = 0 (stat = 2) ----------------
    acc_len = 9'd1;
    acc_cycle("len1", 1, 5, 0, 0, 0, 0);
    acc_cycle("len1", 1, -7, 0, 0, 0, 0);
    acc_cycle("len1", 0, 0, 0, 0, 1, 10);
    acc_cycle("len1", 0, 0, 0, 0, 1, -14);
    acc_cycle("len1", 0, 0, 0, 0, 0, 0);
    acc_len = 9'd0;
    acc_cycle("len0", 1, 6, 0, 0, 0, 0);
    acc_cycle("len0", 0, 0, 0, 0, 0, 0);
    acc_cycle("len0", 0, 0, 0, 0, 1, 12);
    acc_cycle("len0", 0, 0, 0, 0, 0, 0);

    // ---------------- contexts and horizontal orientation ----------------
    calc_mode = 1'b0;
    write_stat(0, 1, 1'b1);
    write_stat(1, 2, 1'b1);
    write_stat(2, 3, 1'b1);
    write_stat(3, 4, 1'b1);
    in_left = 8'sd10; in_bottom = 8'sd0;
    for (int c = 0; c <= 4; c++) begin
      in_valid = (c < 4);
      stat_rd_idx = 2'(c);
      tick();
      if (c < 4) begin
        check("ctx_fwd_right", out_right, 10);
        check("ctx_left_zero", out_left, 0);
      end
      if (c >= 1) begin
        $display("  [ctx] rd_idx=%0d -> out_valid=%0b out_top=%0d out_bottom=%0d",
                 c - 1, out_valid, out_top, out_bottom);
        check("ctx_valid", out_valid, 1);
        check("ctx_top", out_top, 10 * c);
        check("ctx_bottom_zero", out_bottom, 0);
      end
    end
    in_valid = 1'b0; in_left = 8'sd0;
    tick();
    check("ctx_drain_valid", out_valid, 0);

    // ---------------- stall mid-accumulation ----------------
    flow_dir = 1'b0; calc_mode = 1'b1; acc_len = 9'd4; stat_rd_idx = 2'd2;
    write_stat(2, 3, 1'b0);
    acc_cycle("stall", 1, 1, 0, 0, 0, 0);
    acc_cycle("stall", 1, 2, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      acc_cycle("stall", 1, 100, 0, 1, 0, 0);
      check("stall_fwd_frozen", out_left, 2);
    end
    acc_cycle("stall", 1, 3, 0, 0, 0, 0);
    acc_cycle("stall", 1, 4, 0, 0, 0, 0);
    acc_cycle("stall", 0, 0, 0, 0, 0, 0);
    acc_cycle("stall", 0, 0, 0, 0, 1, 30);
    acc_cycle("stall", 0, 0, 0, 1, 1, 30);
    acc_cycle("stall", 0, 0, 0, 0, 0, 0);
    check("stall_hold_sum", out_bottom, 30);

    // ---------------- reset mid-accumulation ----------------
    acc_cycle("rstacc", 1, 1, 0, 0, 0, 0);
    acc_cycle("rstacc", 1, 2, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    check("rstacc_valid",  out_valid,  0);
    check("rstacc_bottom", out_bottom, 0);
    check("rstacc_left",   out_left,   0);
    check("rstacc_top",    out_top,    0);
    rst_n = 1'b1;
    write_stat(2, 3, 1'b0);
    check("rstacc_no_emit", out_valid, 0);
    acc_cycle("rstacc", 1, 1, 0, 0, 0, 0);
    acc_cycle("rstacc", 1, 2, 0, 0, 0, 0);
    acc_cycle("rstacc", 1, 3, 0, 0, 0, 0);
    acc_cycle("rstacc", 1, 4, 0, 0, 0, 0);
    acc_cycle("rstacc", 0, 0, 0, 0, 0, 0);
    acc_cycle("rstacc", 0, 0, 0, 0, 1, 30);
    acc_cycle("rstacc", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
